sd_cmd_tx: RTL and testbench
============================

// Module: sd_cmd_tx
// PURPOSE
//  Host-side SD command transmitter; the outbound half of the CMD-line interface.
//  Serialises a 48-bit SD command frame onto the CMD line, MSB first, one bit per clk:
//  start(0), transmission(1), index[5:0], argument[31:0], CRC7[6:0], end(1).
//  Generates CRC7 on the fly, then holds the line released for the Ncc gap.
//  After that it signals done, so the controller can enable the response receiver.
// PARAMETERS
//  NCC_CYCLES  8   released-line clocks after the end bit before done (1..255)
// PORTS
//  clk          in   1   CMD-line bit clock; all state changes on posedge
//  reset        in   1   asynchronous, active-low reset (0 = reset)
//  start        in   1   request to send; sampled only while busy==0
//  cmd_index    in   6   command index, latched on start acceptance
//  argument     in   32  command argument, latched on start acceptance
//  sd_cmd_out   out  1   CMD line data; 1 whenever not driving a frame bit
//  sd_cmd_oe    out  1   CMD line output enable; 1 only during the 48 frame bits
//  busy         out  1   1 from acceptance until the done cycle
//  done         out  1   single-cycle pulse at end of the Ncc gap
// BEHAVIOUR
//  Reset (async, reset==0): state IDLE, sd_cmd_out=1, sd_cmd_oe=0, busy=0, done=0, crc=0,
//   bit counter=0, latched index/arg=0. Reset mid-frame aborts immediately; no end bit is sent.
//  States: IDLE -> FRAME -> CRC -> END -> GAP -> IDLE.
//  IDLE: outputs idle (out=1, oe=0, busy=0). If start==1 at edge T0, latch
//   {2'b01,cmd_index,argument} into a 40-bit shift register. Also set crc=0 and busy=1.
//   Enter FRAME with the counter at 39.
//  FRAME: 40 cycles, T0+1..T0+40. Drive sr[39], oe=1, then shift left.
//   Each bit b updates the CRC: fb = crc[6]^b; crc <= {crc[5:0],1'b0} ^ (fb ? 7'h09 : 7'h00).
//   Polynomial x^7+x^3+1, init 0.
//  CRC: 7 cycles, T0+41..T0+47. Drive crc[6], oe=1, then shift crc left with 0 fill; no further CRC update.
//  END: 1 cycle, T0+48. Drive out=1 with oe=1 (end bit).
//  GAP: NCC_CYCLES cycles with out=1 and oe=0, busy=1.
//  Exit: on the edge after the last GAP cycle, go to IDLE with busy=0 and done=1 for exactly one cycle.
//   done occurs at cycle T0+49+NCC_CYCLES.
//  Start latency: first bit (start bit 0) appears the cycle after acceptance.
//   Total busy span = 48+NCC_CYCLES cycles.
//  start while busy==1: ignored, not queued. Latched index/arg are unaffected by input changes mid-frame.
//  start high in the done cycle (IDLE, busy==0): accepted; the next frame begins the following cycle.
//  start held high continuously: back-to-back frames separated only by GAP plus the IDLE/done cycle.
//  done and busy are never both 1. oe is never 1 outside FRAME/CRC/END.
//  Counter widths: frame counter 6 bits; gap counter 8 bits; no wrap is reachable.
// TESTING
//  1. Reset held, then released with start=0 -> out=1, oe=0, busy=0, done=0 for 20 cycles.
//  2. CMD0, arg 0x00000000 -> frame 0x40_00000000_95 (CRC7=0x4A).
//     Bits appear T0+1..T0+48; done at T0+57 with NCC_CYCLES=8.
//  3. CMD8 arg 0x000001AA -> 0x48_000001AA_87 (CRC 0x43).
//     CMD17 arg 0 -> 0x51_00000000_55 (CRC 0x2A).
//  4. start pulsed at T0+10 and T0+30 during a frame -> ignored; a single frame is sent, a single done.
//     Change argument at T0+5 -> frame unchanged.
//  5. start held high for 3 frames -> three identical frames. Each new start bit appears the cycle after its done.
//  6. reset asserted at T0+20 -> oe=0, out=1, busy=0 immediately (async).
//     After release, a new CMD0 -> correct 0x...95 frame (CRC state cleared).

Source files
------------

// File: rtl/sd_cmd_tx.sv
// SD host command transmitter: serialises start/tx/index/arg/CRC7/end onto CMD,
// then releases the line for the Ncc gap and pulses done.
module sd_cmd_tx #(
  parameter int NCC_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] argument,
  output logic        sd_cmd_out,
  output logic        sd_cmd_oe,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {S_IDLE, S_FRAME, S_CRC, S_END, S_GAP} state_t;

  state_t      state, nxt;
  logic [39:0] sr;
  logic [6:0]  crc;
  logic [5:0]  cnt;
  logic [7:0]  gcnt;
  logic        done_r;
  logic        fb;

  assign fb = crc[6] ^ sr[39];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt        = state;
    sd_cmd_out = 1'b1;
    sd_cmd_oe  = 1'b0;
    busy       = (state != S_IDLE);
    done       = done_r;
    case (state)
      S_IDLE:  if (start) nxt = S_FRAME;
      S_FRAME: begin
        sd_cmd_out = sr[39];
        sd_cmd_oe  = 1'b1;
        if (cnt == 6'd0) nxt = S_CRC;
      end
      S_CRC: begin
        sd_cmd_out = crc[6];
        sd_cmd_oe  = 1'b1;
        if (cnt == 6'd0) nxt = S_END;
      end
      S_END: begin
        sd_cmd_oe = 1'b1;
        nxt       = S_GAP;
      end
      S_GAP:   if (gcnt == 8'(NCC_CYCLES - 1)) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Datapath: shift register, CRC, counters, and the one-cycle done flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr     <= '0;
      crc    <= '0;
      cnt    <= '0;
      gcnt   <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          sr  <= {2'b01, cmd_index, argument};
          crc <= '0;
          cnt <= 6'd39;
        end
        S_FRAME: begin
          sr  <= {sr[38:0], 1'b0};
          crc <= {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
          cnt <= (cnt == 6'd0) ? 6'd6 : cnt - 6'd1;
        end
        S_CRC: begin
          crc <= {crc[5:0], 1'b0};
          cnt <= cnt - 6'd1;
        end
        S_END: gcnt <= '0;
        S_GAP: begin
          gcnt <= gcnt + 8'd1;
          if (gcnt == 8'(NCC_CYCLES - 1)) done_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_tx.sv
// Bench for sd_cmd_tx: directed and random frames checked cycle-by-cycle against
// a frame model built from polynomial long division.
module tb_sd_cmd_tx;
  localparam int NCC = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  cmd_index = '0;
  logic [31:0] argument = '0;
  logic        sd_cmd_out, sd_cmd_oe, busy, done;

  int tests = 0;
  int fails = 0;

  sd_cmd_tx #(.NCC_CYCLES(NCC)) dut (
    .clk(clk), .reset(reset), .start(start), .cmd_index(cmd_index),
    .argument(argument), .sd_cmd_out(sd_cmd_out), .sd_cmd_oe(sd_cmd_oe),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // CRC7 as the remainder of msg * x^7 divided by x^7+x^3+1.
  function automatic logic [6:0] crc7_ref(input logic [39:0] msg);
    logic [46:0] m;
    m = {msg, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (m[i]) m = m ^ (47'h89 << (i - 7));
    return m[6:0];
  endfunction

  function automatic logic [47:0] frame_ref(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] msg;
    msg = {2'b01, idx, arg};
    return {msg, crc7_ref(msg), 1'b1};
  endfunction

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one command (start already sampled at the next posedge) and checks
  // {out,oe,busy,done} every cycle through the done cycle.
  task automatic send(input logic [5:0] idx, input logic [31:0] arg, input bit hold,
                      input bit disturb, output logic [47:0] got);
    logic [47:0] exp;
    logic [3:0]  e;
    exp = frame_ref(idx, arg);
    cmd_index = idx;
    argument  = arg;
    start     = 1'b1;
    got       = '0;
    for (int k = 1; k <= 49 + NCC; k++) begin
      @(negedge clk);
      if (k <= 48) begin
        e = {exp[48-k], 3'b110};
        got[48-k] = sd_cmd_out;
      end else if (k < 49 + NCC) e = 4'b1010;
      else                       e = 4'b1001;
      chk($sformatf("cmd%0d_cyc%0d", idx, k), 48'({sd_cmd_out, sd_cmd_oe, busy, done}), 48'(e));
      if (!hold) start = disturb && (k == 10 || k == 30);
      if (disturb && k == 5) begin
        argument  = $urandom;
        cmd_index = 6'($urandom);
      end
    end
    chk($sformatf("cmd%0d_frame", idx), got, exp);
  endtask

  logic [47:0] got, first;

  initial begin
    repeat (3) @(negedge clk);
    chk("in_reset", 48'({sd_cmd_out, sd_cmd_oe, busy, done}), 48'h8);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle", 48'({sd_cmd_out, sd_cmd_oe, busy, done}), 48'h8);
    end

    send(6'd0, 32'h0, 0, 0, got);
    chk("cmd0_const", got, 48'h40_0000_0000_95);
    send(6'd8, 32'h1AA, 0, 0, got);
    chk("cmd8_const", got, 48'h48_0000_01AA_87);
    send(6'd17, 32'h0, 0, 0, got);
    chk("cmd17_const", got, 48'h51_0000_0000_55);

    for (int i = 0; i < 4; i++) send(6'($urandom), $urandom, 0, 0, got);

    // Mid-frame start pulses and input changes must not disturb the frame.
    send(6'($urandom), $urandom, 0, 1, got);
    repeat (3) begin
      @(negedge clk);
      chk("idle_after_disturb", 48'({sd_cmd_out, sd_cmd_oe, busy, done}), 48'h8);
    end

    // Back-to-back frames with start held high.
    send(6'd3, 32'hDEADBEEF, 1, 0, first);
    for (int i = 0; i < 2; i++) begin
      send(6'd3, 32'hDEADBEEF, 1, 0, got);
      chk("b2b_same", got, first);
    end
    start = 1'b0;
    @(negedge clk);
    chk("idle_after_b2b", 48'({sd_cmd_out, sd_cmd_oe, busy, done}), 48'h8);

    // Asynchronous reset mid-frame, then a clean CMD0.
    cmd_index = 6'd17;
    argument  = $urandom;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    chk("pre_reset_oe", 48'(sd_cmd_oe), 48'h1);
    reset = 1'b0;
    #1;
    chk("async_reset", 48'({sd_cmd_out, sd_cmd_oe, busy, done}), 48'h8);
    repeat (2) begin
      @(negedge clk);
      chk("reset_held", 48'({sd_cmd_out, sd_cmd_oe, busy, done}), 48'h8);
    end
    reset = 1'b1;
    @(negedge clk);
    send(6'd0, 32'h0, 0, 0, got);
    chk("cmd0_after_reset", got, 48'h40_0000_0000_95);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
